// File: rtl/cv32e40p_tb_obi_mem.sv
// Multi-port OBI memory model for the core testbench.
// Shared byte RAM, per-port response FIFOs, optional stalls, exit register.
module cv32e40p_tb_obi_mem #(
  parameter int          NUM_PORTS       = 2,
  parameter int          ADDR_WIDTH      = 20,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          RESP_LATENCY    = 1,
  parameter int          STALL_EN        = 0,
  parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_PORTS-1:0]     req_i,
  output logic [NUM_PORTS-1:0]     gnt_o,
  input  logic [NUM_PORTS*32-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]     we_i,
  input  logic [NUM_PORTS*4-1:0]   be_i,
  input  logic [NUM_PORTS*32-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]     rvalid_o,
  output logic [NUM_PORTS*32-1:0]  rdata_o,
  output logic                     exit_valid_o,
  output logic [31:0]              exit_value_o
);

  localparam int NP    = NUM_PORTS;
  localparam int MO    = MAX_OUTSTANDING;
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int PW    = (MO > 1) ? $clog2(MO) : 1;
  localparam int CNTW  = $clog2(MO + 1);
  localparam int CDW   = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  localparam logic [CDW-1:0]  CD_INIT  = CDW'(RESP_LATENCY - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MO);
  localparam logic [PW-1:0]   PTR_LAST = PW'(MO - 1);

  logic [31:0]           ram [DEPTH];
  logic [15:0]           lfsr [NP];
  logic [CNTW-1:0]       cnt [NP];
  logic [PW-1:0]         wptr [NP];
  logic [PW-1:0]         rptr [NP];
  logic [31:0]           fifo_data [NP][MO];
  logic [CDW-1:0]        fifo_cd [NP][MO];

  logic [NP-1:0]         gnt;
  logic [NP-1:0]         pop;
  logic [NP-1:0]         gstall;
  logic [NP-1:0]         rstall;
  logic [NP-1:0]         in_range;
  logic [NP-1:0]         is_exit;
  logic [31:0]           addr [NP];
  logic [31:0]           wdata [NP];
  logic [31:0]           rword [NP];
  logic [3:0]            be [NP];
  logic [ADDR_WIDTH-3:0] widx [NP];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    return (v == PTR_LAST) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      addr[p]     = addr_i[32*p +: 32];
      wdata[p]    = wdata_i[32*p +: 32];
      be[p]       = be_i[4*p +: 4];
      widx[p]     = addr[p][ADDR_WIDTH-1:2];
      in_range[p] = (addr[p] >> ADDR_WIDTH) == 32'd0;
      is_exit[p]  = addr[p] == EXIT_ADDR;
      gstall[p]   = (STALL_EN != 0) && (lfsr[p][1:0] == 2'b00);
      rstall[p]   = (STALL_EN != 0) && lfsr[p][3];
      gnt[p]      = req_i[p] & ~rst_i & ~gstall[p]
                  & (cnt[p] < CNT_MAX);
      pop[p]      = ~rst_i & (cnt[p] != '0) & ~rstall[p]
                  & (fifo_cd[p][rptr[p]] == '0);
      rword[p]    = (we_i[p] | ~in_range[p]) ? 32'd0
                                             : ram[widx[p]];
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NP; p++) begin
      if (pop[p]) rdata_o[32*p +: 32] = fifo_data[p][rptr[p]];
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = pop;

  // Descending loop: lowest port's lane write is applied last and wins.
  always_ff @(posedge clk_i) begin
    for (int p = NP - 1; p >= 0; p--) begin
      if (gnt[p] && we_i[p] && in_range[p] && !is_exit[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[p][b]) ram[widx[p]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NP; p++) begin
        lfsr[p] <= 16'hACE1 ^ 16'(p);
        cnt[p]  <= '0;
        wptr[p] <= '0;
        rptr[p] <= '0;
        for (int e = 0; e < MO; e++) fifo_cd[p][e] <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        lfsr[p] <= {lfsr[p][14:0],
                    lfsr[p][15] ^ lfsr[p][13] ^ lfsr[p][12] ^ lfsr[p][10]};
        for (int e = 0; e < MO; e++) begin
          if (fifo_cd[p][e] != '0) fifo_cd[p][e] <= fifo_cd[p][e] - 1'b1;
        end
        if (gnt[p]) begin
          fifo_data[p][wptr[p]] <= rword[p];
          fifo_cd[p][wptr[p]]   <= CD_INIT;
          wptr[p]               <= ptr_inc(wptr[p]);
        end
        if (pop[p]) rptr[p] <= ptr_inc(rptr[p]);
        if (gnt[p] && !pop[p]) cnt[p] <= cnt[p] + 1'b1;
        else if (!gnt[p] && pop[p]) cnt[p] <= cnt[p] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_valid_o <= 1'b0;
      exit_value_o <= 32'd0;
    end else begin
      exit_valid_o <= 1'b0;
      for (int p = NP - 1; p >= 0; p--) begin
        if (gnt[p] && we_i[p] && is_exit[p]) begin
          exit_valid_o <= 1'b1;
          exit_value_o <= wdata[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tb_obi_mem.sv
// Directed and randomized checks of the multi-port OBI memory model.
// Three instances: default, shallow/slow FIFO, and stalling.
module tb_cv32e40p_tb_obi_mem;

  localparam logic [31:0] EXIT = 32'h2000_0004;
  localparam int N = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instance A: default parameters
  logic        a_rst;
  logic [1:0]  a_req, a_gnt, a_we, a_rvalid;
  logic [63:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_be;
  logic        a_exit_valid;
  logic [31:0] a_exit_value;

  cv32e40p_tb_obi_mem dut_a (
    .clk_i(clk), .rst_i(a_rst), .req_i(a_req), .gnt_o(a_gnt),
    .addr_i(a_addr), .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata),
    .rvalid_o(a_rvalid), .rdata_o(a_rdata),
    .exit_valid_o(a_exit_valid), .exit_value_o(a_exit_value)
  );

  // Instance B: single port, depth 2, latency 4
  logic        b_rst, b_req, b_gnt, b_we, b_rvalid, b_exv;
  logic [31:0] b_addr, b_wdata, b_rdata, b_exval;
  logic [3:0]  b_be;

  cv32e40p_tb_obi_mem #(
    .NUM_PORTS(1), .ADDR_WIDTH(12), .MAX_OUTSTANDING(2),
    .RESP_LATENCY(4)
  ) dut_b (
    .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .gnt_o(b_gnt),
    .addr_i(b_addr), .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata),
    .rvalid_o(b_rvalid), .rdata_o(b_rdata),
    .exit_valid_o(b_exv), .exit_value_o(b_exval)
  );

  // Instance C: random stalls
  logic        c_rst;
  logic [1:0]  c_req, c_gnt, c_we, c_rvalid;
  logic [63:0] c_addr, c_wdata, c_rdata;
  logic [7:0]  c_be;
  logic        c_exv;
  logic [31:0] c_exval;

  cv32e40p_tb_obi_mem #(
    .NUM_PORTS(2), .ADDR_WIDTH(10), .MAX_OUTSTANDING(4),
    .RESP_LATENCY(2), .STALL_EN(1)
  ) dut_c (
    .clk_i(clk), .rst_i(c_rst), .req_i(c_req), .gnt_o(c_gnt),
    .addr_i(c_addr), .we_i(c_we), .be_i(c_be), .wdata_i(c_wdata),
    .rvalid_o(c_rvalid), .rdata_o(c_rdata),
    .exit_valid_o(c_exv), .exit_value_o(c_exval)
  );

  logic [31:0] a_rd0, a_rd1, a_exval_s;
  logic        a_exv_s;

  // One handshake cycle on A; expects immediate grant and rvalid next cycle.
  task automatic a_op(input string tag, input logic [1:0] rq,
                      input logic [1:0] we,
                      input logic [31:0] ad0, input logic [31:0] ad1,
                      input logic [3:0] be0, input logic [3:0] be1,
                      input logic [31:0] wd0, input logic [31:0] wd1);
    @(posedge clk); #1;
    a_req   = rq;
    a_we    = we;
    a_addr  = {ad1, ad0};
    a_be    = {be1, be0};
    a_wdata = {wd1, wd0};
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(a_gnt), 32'(rq));
    @(posedge clk); #1;
    a_req = 2'b00;
    @(negedge clk);
    chk({tag, "_rvalid"}, 32'(a_rvalid), 32'(rq));
    a_rd0     = a_rdata[31:0];
    a_rd1     = a_rdata[63:32];
    a_exv_s   = a_exit_valid;
    a_exval_s = a_exit_value;
  endtask

  // Random-phase state for C
  logic [1:0]  c_act;
  int          c_cnt [2];
  int          issued [2];
  int          c_word [2];
  logic [31:0] c_adv [2];
  logic [31:0] c_wdv [2];
  logic [3:0]  c_bev [2];
  logic        c_wev [2];
  logic [31:0] cm [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tp_addr [4];
    logic [31:0] tp_exp [4];
    logic [9:0]  gexp, rexp;
    logic [31:0] e;
    int          cyc;

    a_rst = 1'b1; a_req = 2'b11; a_we = 2'b00; a_addr = '0;
    a_be = 8'hFF; a_wdata = '0;
    b_rst = 1'b1; b_req = 1'b0; b_we = 1'b0; b_addr = '0;
    b_be = 4'hF; b_wdata = '0;
    c_rst = 1'b1; c_req = 2'b00; c_we = 2'b00; c_addr = '0;
    c_be = 8'hFF; c_wdata = '0;
    c_act = 2'b00;
    for (int p = 0; p < 2; p++) begin
      c_cnt[p] = 0; issued[p] = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(a_gnt), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rdata_lo", a_rdata[31:0], 32'd0);
    chk("rst_rdata_hi", a_rdata[63:32], 32'd0);
    chk("rst_exit_valid", 32'(a_exit_valid), 32'd0);
    chk("rst_exit_value", a_exit_value, 32'd0);
    @(posedge clk); #1;
    a_rst = 1'b0; a_req = 2'b00;
    b_rst = 1'b0; c_rst = 1'b0;

    a_op("t1w", 2'b01, 2'b01, 32'h100, 0, 4'hF, 0, 32'hCAFEBABE, 0);
    chk("t1w_rdata", a_rd0, 32'd0);
    a_op("t1r", 2'b01, 2'b00, 32'h100, 0, 4'hF, 0, 0, 0);
    chk("t1r_rdata", a_rd0, 32'hCAFEBABE);

    a_op("t2w", 2'b01, 2'b01, 32'h104, 0, 4'hF, 0, 32'hAAAAAAAA, 0);
    a_op("t2m", 2'b01, 2'b01, 32'h104, 0, 4'b0101, 0, 32'h11223344, 0);
    a_op("t2r", 2'b01, 2'b00, 32'h104, 0, 4'hF, 0, 0, 0);
    chk("t2r_rdata", a_rd0, 32'hAA22AA44);
    a_op("t2lo", 2'b10, 2'b00, 0, 32'h107, 0, 4'hF, 0, 0);
    chk("t2lo_rdata", a_rd1, 32'hAA22AA44);

    a_op("t4w", 2'b11, 2'b11, 32'h200, 32'h200, 4'hF, 4'hF,
         32'h11111111, 32'h22222222);
    a_op("t4r", 2'b01, 2'b00, 32'h200, 0, 4'hF, 0, 0, 0);
    chk("t4r_rdata", a_rd0, 32'h11111111);
    a_op("t4lw", 2'b11, 2'b11, 32'h204, 32'h204, 4'b0011, 4'hF,
         32'h33333333, 32'h44444444);
    a_op("t4lr", 2'b01, 2'b00, 32'h204, 0, 4'hF, 0, 0, 0);
    chk("t4lane_rdata", a_rd0, 32'h44443333);

    a_op("rw0", 2'b01, 2'b01, 32'h300, 0, 4'hF, 0, 32'h55, 0);
    a_op("rw1", 2'b11, 2'b01, 32'h300, 32'h300, 4'hF, 4'hF, 32'h66, 0);
    chk("rw_old_rdata", a_rd1, 32'h55);
    chk("rw_wr_rdata", a_rd0, 32'd0);
    a_op("rw2", 2'b10, 2'b00, 0, 32'h300, 0, 4'hF, 0, 0);
    chk("rw_new_rdata", a_rd1, 32'h66);

    a_op("oorw", 2'b01, 2'b01, 32'h0010_0100, 0, 4'hF, 0,
         32'hBAD0BAD0, 0);
    a_op("oora", 2'b01, 2'b00, 32'h100, 0, 4'hF, 0, 0, 0);
    chk("oor_alias", a_rd0, 32'hCAFEBABE);
    a_op("oorr", 2'b10, 2'b00, 0, 32'h0010_0100, 0, 4'hF, 0, 0);
    chk("oor_read", a_rd1, 32'd0);

    a_op("t5pre", 2'b01, 2'b01, 32'h4, 0, 4'hF, 0, 32'h77, 0);
    a_op("t5x", 2'b01, 2'b01, EXIT, 0, 4'hF, 0, 32'h2A, 0);
    chk("exit_valid", 32'(a_exv_s), 32'd1);
    chk("exit_value", a_exval_s, 32'h2A);
    @(negedge clk);
    chk("exit_pulse_end", 32'(a_exit_valid), 32'd0);
    chk("exit_value_hold", a_exit_value, 32'h2A);
    a_op("t5r", 2'b01, 2'b00, 32'h4, 0, 4'hF, 0, 0, 0);
    chk("exit_ram_intact", a_rd0, 32'h77);
    a_op("t5xr", 2'b01, 2'b00, EXIT, 0, 4'hF, 0, 0, 0);
    chk("exit_read", a_rd0, 32'd0);
    a_op("t5xx", 2'b11, 2'b11, EXIT, EXIT, 4'hF, 4'hF, 32'h1, 32'h2);
    chk("exit2_valid", 32'(a_exv_s), 32'd1);
    chk("exit2_value", a_exval_s, 32'h1);

    tp_addr[0] = 32'h100; tp_exp[0] = 32'hCAFEBABE;
    tp_addr[1] = 32'h104; tp_exp[1] = 32'hAA22AA44;
    tp_addr[2] = 32'h200; tp_exp[2] = 32'h11111111;
    tp_addr[3] = 32'h204; tp_exp[3] = 32'h44443333;
    @(posedge clk); #1;
    a_req = 2'b01; a_we = 2'b00; a_addr = {32'd0, tp_addr[0]};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_gnt", 32'(a_gnt), 32'd1);
      chk("b2b_rvalid", 32'(a_rvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("b2b_rdata", a_rdata[31:0], tp_exp[i-1]);
      @(posedge clk); #1;
      if (i < 3) a_addr = {32'd0, tp_addr[i+1]};
      else a_req = 2'b00;
    end
    @(negedge clk);
    chk("b2b_rvalid_last", 32'(a_rvalid), 32'd1);
    chk("b2b_rdata_last", a_rdata[31:0], tp_exp[3]);

    gexp = 10'b0000100011;
    rexp = 10'b1000110000;
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h10;
    b_wdata = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_gnt", 32'(b_gnt), 32'(gexp[i]));
      chk("t3_rvalid", 32'(b_rvalid), 32'(rexp[i]));
      if (b_rvalid) chk("t3_rdata", b_rdata, 32'd0);
      @(posedge clk); #1;
      if (i == 5) b_req = 1'b0;
    end

    b_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_req = 1'b0; b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b_rst_drop", 32'(b_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    b_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_rst_cnt_gnt", 32'(b_gnt), (i < 2) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    b_req = 1'b0;

    cyc = 0;
    while ((issued[0] < N || issued[1] < N || c_act != 2'b00 ||
            q0.size() != 0 || q1.size() != 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (!c_act[p] && issued[p] < N) begin
          if (issued[p] < 16) begin
            c_wev[p]  = 1'b1;
            c_word[p] = 16 * p + issued[p];
            c_bev[p]  = 4'hF;
          end else begin
            c_wev[p]  = 1'($urandom_range(0, 1));
            c_word[p] = 16 * p + int'($urandom_range(0, 15));
            c_bev[p]  = 4'($urandom_range(1, 15));
          end
          c_wdv[p] = $urandom;
          c_adv[p] = 32'(c_word[p] * 4) + 32'($urandom_range(0, 3));
          c_act[p] = 1'b1;
          issued[p]++;
        end
      end
      c_req   = c_act;
      c_we    = {c_wev[1], c_wev[0]};
      c_addr  = {c_adv[1], c_adv[0]};
      c_be    = {c_bev[1], c_bev[0]};
      c_wdata = {c_wdv[1], c_wdv[0]};
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (c_cnt[p] == 4) chk("c_gnt_full", 32'(c_gnt[p]), 32'd0);
        if (c_rvalid[p]) begin
          if (p == 0) begin
            if (q0.size() == 0) chk("c_spurious0", 32'd1, 32'd0);
            else chk("c_rdata0", c_rdata[31:0], q0.pop_front());
          end else begin
            if (q1.size() == 0) chk("c_spurious1", 32'd1, 32'd0);
            else chk("c_rdata1", c_rdata[63:32], q1.pop_front());
          end
          c_cnt[p]--;
        end
        if (c_gnt[p]) begin
          e = c_wev[p] ? 32'd0 : cm[c_word[p]];
          if (p == 0) q0.push_back(e);
          else q1.push_back(e);
          if (c_wev[p]) begin
            for (int b = 0; b < 4; b++) begin
              if (c_bev[p][b])
                cm[c_word[p]][8*b +: 8] = c_wdv[p][8*b +: 8];
            end
          end
          c_cnt[p]++;
          c_act[p] = 1'b0;
        end
      end
    end
    chk("c_drain", (cyc < 20000) ? 32'd1 : 32'd0, 32'd1);

    @(posedge clk); #1;
    c_req = 2'b11; c_we = 2'b00; c_addr = {32'h40, 32'h0};
    repeat (12) @(posedge clk);
    #1 c_rst = 1'b1;
    @(posedge clk); #1;
    c_rst = 1'b0; c_req = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("c_rst_drop", 32'(c_rvalid), 32'd0);
    end

    @(posedge clk); #1;
    c_rst = 1'b1; c_req = 2'b11;
    @(posedge clk); #1;
    c_rst = 1'b0;
    @(negedge clk);
    chk("c_seed_gnt", 32'(c_gnt), 32'd1);
    @(posedge clk); #1;
    c_req = 2'b00;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
